// File: rtl/gamepad_input_conditioner.sv
// gamepad_input_conditioner
//
// Conditions raw gamepad buttons before they reach the USB gamepad controller FSM.
// Each raw input first passes through a two-flop synchroniser and then a counting
// debouncer. An arbiter turns each accepted press into a one-hot pulse that lasts
// PULSE_CYCLES. Downstream logic therefore never sees two buttons high at once.
// While a button stays held, the arbiter can optionally re-pulse it (auto-repeat).
//
// Ports:
//   clk           system clock
//   reset         synchronous, active-high reset
//   raw_mode_i    raw mode switch (async, bouncing)
//   raw_*_i       raw buttons L,R,U,D,A,B,X,Y (async, bouncing)
//   mode_o        synchronised and debounced mode level
//   L_o..Y_o      conditioned buttons; at most one of the eight is high in any cycle
//   busy_o        high whenever the arbiter is not idle
//   drop_cnt_o    saturating count of button rises discarded while the arbiter was busy
module gamepad_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int PULSE_CYCLES    = 2,
    parameter int REPEAT_CYCLES   = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       raw_mode_i,
    input  logic       raw_L_i,
    input  logic       raw_R_i,
    input  logic       raw_U_i,
    input  logic       raw_D_i,
    input  logic       raw_A_i,
    input  logic       raw_B_i,
    input  logic       raw_X_i,
    input  logic       raw_Y_i,
    output logic       mode_o,
    output logic       L_o,
    output logic       R_o,
    output logic       U_o,
    output logic       D_o,
    output logic       A_o,
    output logic       B_o,
    output logic       X_o,
    output logic       Y_o,
    output logic       busy_o,
    output logic [7:0] drop_cnt_o
);

    localparam int NIN = 9;
    localparam int CW  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int PW  = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
    localparam int RW  = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [PW-1:0] P_LAST  = PW'(PULSE_CYCLES - 1);
    localparam logic [RW-1:0] R_LAST  = RW'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, ACTIVE, HOLD, RELEASE} state_t;

    // Bit order: 0..7 = L,R,U,D,A,B,X,Y. The lowest index wins arbitration. Bit 8 is mode.
    logic [NIN-1:0] rawVec;
    logic [NIN-1:0] sync1_q, sync2_q;
    logic [NIN-1:0] db_q, db_d;
    logic [CW-1:0]  dbCnt_q [NIN];
    logic [CW-1:0]  dbCnt_d [NIN];
    logic [7:0]     rise_q, rise_d;

    state_t         state_q, state_d;
    logic [2:0]     sel_q, sel_d;
    logic [PW-1:0]  pcnt_q, pcnt_d;
    logic [RW-1:0]  hcnt_q, hcnt_d;
    logic [7:0]     btnOut_q, btnOut_d;
    logic           busy_q, busy_d;
    logic           mode_q;
    logic [7:0]     dropCnt_q, dropCnt_d;

    logic [2:0]     pick;
    logic [3:0]     riseCount;
    logic [3:0]     dropInc;
    logic [8:0]     dropSum;

    assign rawVec = {raw_mode_i, raw_Y_i, raw_X_i, raw_B_i, raw_A_i,
                     raw_D_i, raw_U_i, raw_R_i, raw_L_i};

    // Two-flop synchroniser for every raw input.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= rawVec;
            sync2_q <= sync1_q;
        end
    end

    // Debounce: count consecutive cycles in which the synced value disagrees with the
    // debounced value. Any agreement restarts the count. On the last count, the debounced
    // value flips and the counter clears. rise_d flags a 0->1 flip of a button, which is
    // registered so that the flag lasts exactly one cycle.
    always_comb begin
        for (int i = 0; i < NIN; i++) begin
            dbCnt_d[i] = '0;
            db_d[i]    = db_q[i];
            if (sync2_q[i] != db_q[i]) begin
                if (dbCnt_q[i] == DB_LAST) begin
                    db_d[i] = ~db_q[i];
                end else begin
                    dbCnt_d[i] = dbCnt_q[i] + 1'b1;
                end
            end
        end
        rise_d = db_d[7:0] & ~db_q[7:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            db_q   <= '0;
            rise_q <= '0;
            for (int i = 0; i < NIN; i++) begin
                dbCnt_q[i] <= '0;
            end
        end else begin
            db_q   <= db_d;
            rise_q <= rise_d;
            for (int i = 0; i < NIN; i++) begin
                dbCnt_q[i] <= dbCnt_d[i];
            end
        end
    end

    // Arbiter selection logic. The winner is the lowest-index rise. Every other rise in
    // the same cycle is dropped, and while the arbiter is busy every rise is dropped.
    // The drop counter saturates at 8'hFF.
    always_comb begin
        pick      = 3'd0;
        riseCount = 4'd0;
        for (int i = 7; i >= 0; i--) begin
            if (rise_q[i]) begin
                pick = 3'(i);
            end
        end
        for (int i = 0; i < 8; i++) begin
            riseCount = riseCount + {3'd0, rise_q[i]};
        end
        if (state_q != IDLE) begin
            dropInc = riseCount;
        end else if (riseCount != 4'd0) begin
            dropInc = riseCount - 4'd1;
        end else begin
            dropInc = 4'd0;
        end
        dropSum   = {1'b0, dropCnt_q} + {5'd0, dropInc};
        dropCnt_d = dropSum[8] ? 8'hFF : dropSum[7:0];
    end

    // Arbiter next-state logic. In HOLD, a released selected button takes priority over
    // the repeat timer. The one-hot outputs and busy are registered from the next state,
    // so they change on the same edge as the state.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        pcnt_d  = pcnt_q;
        hcnt_d  = hcnt_q;
        case (state_q)
            IDLE: begin
                if (rise_q != 8'd0) begin
                    sel_d   = pick;
                    pcnt_d  = '0;
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                if (pcnt_q == P_LAST) begin
                    hcnt_d  = '0;
                    state_d = HOLD;
                end else begin
                    pcnt_d = pcnt_q + 1'b1;
                end
            end
            HOLD: begin
                if (!db_q[sel_q]) begin
                    state_d = (db_q[7:0] != 8'd0) ? RELEASE : IDLE;
                end else if (REPEAT_CYCLES != 0) begin
                    if (hcnt_q == R_LAST) begin
                        pcnt_d  = '0;
                        state_d = ACTIVE;
                    end else begin
                        hcnt_d = hcnt_q + 1'b1;
                    end
                end
            end
            RELEASE: begin
                if (db_q[7:0] == 8'd0) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        btnOut_d = (state_d == ACTIVE) ? (8'd1 << sel_d) : 8'd0;
        busy_d   = (state_d != IDLE);
    end

    // Arbiter and output registers. The mode flop adds one stage after its debouncer,
    // which gives mode the same latency as the buttons.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            pcnt_q    <= '0;
            hcnt_q    <= '0;
            btnOut_q  <= '0;
            busy_q    <= 1'b0;
            mode_q    <= 1'b0;
            dropCnt_q <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            pcnt_q    <= pcnt_d;
            hcnt_q    <= hcnt_d;
            btnOut_q  <= btnOut_d;
            busy_q    <= busy_d;
            mode_q    <= db_q[8];
            dropCnt_q <= dropCnt_d;
        end
    end

    assign {Y_o, X_o, B_o, A_o, D_o, U_o, R_o, L_o} = btnOut_q;
    assign busy_o     = busy_q;
    assign mode_o     = mode_q;
    assign drop_cnt_o = dropCnt_q;

endmodule

// File: tb/tb_gamepad_input_conditioner.sv
// tb_gamepad_input_conditioner
//
// Directed bench for gamepad_input_conditioner, which is built here with
// DEBOUNCE_CYCLES=4, PULSE_CYCLES=2 and REPEAT_CYCLES=8. Inputs change on the falling
// clock edge. The first rising edge after a change is called edge k. After the falling
// edge that follows edge k+i, the bench compares the outputs against values it worked
// out by hand.
module tb_gamepad_input_conditioner;

    logic       clk = 1'b0;
    logic       reset;
    logic       rawMode;
    logic [7:0] rawBtn;
    wire        modeOut;
    wire        busyOut;
    wire  [7:0] outBtn;
    wire  [7:0] dropCnt;
    int         total = 0;
    int         bad = 0;

    gamepad_input_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .PULSE_CYCLES(2),
        .REPEAT_CYCLES(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .raw_mode_i(rawMode),
        .raw_L_i(rawBtn[0]),
        .raw_R_i(rawBtn[1]),
        .raw_U_i(rawBtn[2]),
        .raw_D_i(rawBtn[3]),
        .raw_A_i(rawBtn[4]),
        .raw_B_i(rawBtn[5]),
        .raw_X_i(rawBtn[6]),
        .raw_Y_i(rawBtn[7]),
        .mode_o(modeOut),
        .L_o(outBtn[0]),
        .R_o(outBtn[1]),
        .U_o(outBtn[2]),
        .D_o(outBtn[3]),
        .A_o(outBtn[4]),
        .B_o(outBtn[5]),
        .X_o(outBtn[6]),
        .Y_o(outBtn[7]),
        .busy_o(busyOut),
        .drop_cnt_o(dropCnt)
    );

    always #5 clk = ~clk;

    // Ends a stuck run with a reported failure instead of letting it hang.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advances past one rising edge and returns at the next falling edge.
    task automatic waitEdge();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Applies one synchronous reset edge with every raw input low, then lets the design settle.
    task automatic doReset();
        @(negedge clk);
        reset   = 1'b1;
        rawBtn  = 8'd0;
        rawMode = 1'b0;
        waitEdge();
        reset = 1'b0;
        repeat (3) waitEdge();
    endtask

    // Checks that every output is cleared after reset.
    task automatic test_reset();
        doReset();
        total++;
        if (outBtn !== 8'd0) begin
            bad++;
            $display("[TB] FAIL reset_out: got %h expected 00", outBtn);
        end
        total++;
        if (busyOut !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_busy: got %b expected 0", busyOut);
        end
        total++;
        if (dropCnt !== 8'd0) begin
            bad++;
            $display("[TB] FAIL reset_drop: got %h expected 00", dropCnt);
        end
        total++;
        if (modeOut !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_mode: got %b expected 0", modeOut);
        end
    endtask

    // R is pressed at edge k and released so that edge k+8 samples it low.
    // R pulses after edges k+6 and k+7. The debounced release lands after k+13,
    // so busy is high from k+6 through k+13.
    task automatic test_single_press();
        logic [7:0] expOut;
        logic       expBusy;
        doReset();
        rawBtn[1] = 1'b1;
        for (int i = 0; i <= 20; i++) begin
            waitEdge();
            expOut  = (i == 6 || i == 7) ? 8'h02 : 8'h00;
            expBusy = (i >= 6 && i <= 13);
            total++;
            if (outBtn !== expOut) begin
                bad++;
                $display("[TB] FAIL single_out@%0d: got %h expected %h", i, outBtn, expOut);
            end
            total++;
            if (busyOut !== expBusy) begin
                bad++;
                $display("[TB] FAIL single_busy@%0d: got %b expected %b", i, busyOut, expBusy);
            end
            if (i == 7) rawBtn[1] = 1'b0;
        end
    endtask

    // A toggles every two cycles, which is too short to pass the debouncer.
    task automatic test_glitch();
        doReset();
        for (int c = 0; c < 30; c++) begin
            rawBtn[4] = (c < 20) && ((c % 4) < 2);
            waitEdge();
            total++;
            if (outBtn !== 8'd0 || busyOut !== 1'b0) begin
                bad++;
                $display("[TB] FAIL glitch@%0d: got out=%h busy=%b expected out=00 busy=0",
                         c, outBtn, busyOut);
            end
        end
        total++;
        if (dropCnt !== 8'd0) begin
            bad++;
            $display("[TB] FAIL glitch_drop: got %h expected 00", dropCnt);
        end
    endtask

    // U and X rise in the same cycle, so U wins and X is dropped once.
    // U is released first, which sends the arbiter to RELEASE because X is still held.
    // X is then released so that edge k+16 samples it low. X debounces low after k+21,
    // and the arbiter returns to IDLE at k+22.
    task automatic test_simultaneous();
        logic [7:0] expOut;
        logic       expBusy;
        logic [7:0] expDrop;
        doReset();
        rawBtn[2] = 1'b1;
        rawBtn[6] = 1'b1;
        for (int i = 0; i <= 25; i++) begin
            waitEdge();
            expOut  = (i == 6 || i == 7) ? 8'h04 : 8'h00;
            expBusy = (i >= 6 && i <= 21);
            expDrop = (i >= 6) ? 8'd1 : 8'd0;
            total++;
            if (outBtn !== expOut) begin
                bad++;
                $display("[TB] FAIL simul_out@%0d: got %h expected %h", i, outBtn, expOut);
            end
            total++;
            if (busyOut !== expBusy) begin
                bad++;
                $display("[TB] FAIL simul_busy@%0d: got %b expected %b", i, busyOut, expBusy);
            end
            total++;
            if (dropCnt !== expDrop) begin
                bad++;
                $display("[TB] FAIL simul_drop@%0d: got %h expected %h", i, dropCnt, expDrop);
            end
            if (i == 7) rawBtn[2] = 1'b0;
            if (i == 15) rawBtn[6] = 1'b0;
        end
    endtask

    // D is held for 40 sampled edges (k..k+39), which gives pulses at offsets 6, 16, 26
    // and 36, each two cycles long. The release debounces after k+45, before the next
    // repeat would fire, so the arbiter goes idle at k+46.
    task automatic test_auto_repeat();
        logic [7:0] expOut;
        logic       expBusy;
        doReset();
        rawBtn[3] = 1'b1;
        for (int i = 0; i <= 55; i++) begin
            waitEdge();
            expOut  = (i >= 6 && i <= 37 && ((i - 6) % 10) < 2) ? 8'h08 : 8'h00;
            expBusy = (i >= 6 && i <= 45);
            total++;
            if (outBtn !== expOut) begin
                bad++;
                $display("[TB] FAIL repeat_out@%0d: got %h expected %h", i, outBtn, expOut);
            end
            total++;
            if (busyOut !== expBusy) begin
                bad++;
                $display("[TB] FAIL repeat_busy@%0d: got %b expected %b", i, busyOut, expBusy);
            end
            if (i == 39) rawBtn[3] = 1'b0;
        end
    endtask

    // L is held. Reset is sampled at edge k+7, during the pulse, and clears the pulse.
    // The synchroniser restarts at edge k+8, so L pulses again after k+14 and k+15.
    task automatic test_reset_mid_active();
        logic [7:0] expOut;
        logic       expBusy;
        doReset();
        rawBtn[0] = 1'b1;
        for (int i = 0; i <= 20; i++) begin
            waitEdge();
            reset   = 1'b0;
            expOut  = (i == 6 || i == 14 || i == 15) ? 8'h01 : 8'h00;
            expBusy = (i == 6) || (i >= 14);
            total++;
            if (outBtn !== expOut) begin
                bad++;
                $display("[TB] FAIL rstmid_out@%0d: got %h expected %h", i, outBtn, expOut);
            end
            total++;
            if (busyOut !== expBusy) begin
                bad++;
                $display("[TB] FAIL rstmid_busy@%0d: got %b expected %b", i, busyOut, expBusy);
            end
            if (i == 6) reset = 1'b1;
        end
    endtask

    // L and mode are raised together. Mode then drops during L's pulse without
    // disturbing the pulse. B is then pressed 300 times while L keeps the arbiter busy,
    // so the drop count reads 100 after 100 presses and saturates at FF after 300.
    task automatic test_drop_saturation();
        logic sawB;
        doReset();
        rawBtn[0] = 1'b1;
        rawMode   = 1'b1;
        for (int i = 0; i <= 13; i++) begin
            waitEdge();
            if (i == 5 || i == 6 || i == 12 || i == 13) begin
                total++;
                if (modeOut !== (i == 6 || i == 12)) begin
                    bad++;
                    $display("[TB] FAIL mode@%0d: got %b expected %b", i, modeOut,
                             (i == 6 || i == 12));
                end
            end
            if (i == 6 || i == 7) begin
                total++;
                if (outBtn !== 8'h01) begin
                    bad++;
                    $display("[TB] FAIL mode_pulse@%0d: got %h expected 01", i, outBtn);
                end
            end
            if (i == 6) rawMode = 1'b0;
        end
        sawB = 1'b0;
        for (int p = 0; p < 300; p++) begin
            for (int c = 0; c < 12; c++) begin
                rawBtn[5] = (c < 6);
                waitEdge();
                if (outBtn[5] !== 1'b0) sawB = 1'b1;
            end
            if (p == 99) begin
                total++;
                if (dropCnt !== 8'd100) begin
                    bad++;
                    $display("[TB] FAIL drop_100: got %0d expected 100", dropCnt);
                end
            end
        end
        total++;
        if (dropCnt !== 8'hFF) begin
            bad++;
            $display("[TB] FAIL drop_sat: got %h expected ff", dropCnt);
        end
        total++;
        if (sawB !== 1'b0) begin
            bad++;
            $display("[TB] FAIL drop_noB: got %b expected 0", sawB);
        end
        total++;
        if (busyOut !== 1'b1) begin
            bad++;
            $display("[TB] FAIL drop_busy: got %b expected 1", busyOut);
        end
    endtask

    // Runs every scenario in order and prints the summary.
    initial begin
        reset   = 1'b1;
        rawMode = 1'b0;
        rawBtn  = 8'd0;
        test_reset();
        test_single_press();
        test_glitch();
        test_simultaneous();
        test_auto_repeat();
        test_reset_mid_active();
        test_drop_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
